// File: rtl/capture_ctrl.sv
// Capture sequencer: holdoff, level-crossing trigger search, fixed-length FIFO write, park in DONE.
// Optional macro CAPTURE_AUTO_TRIG_EN adds an ARMED timeout that forces a trigger on flat signals.
module capture_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8,
    parameter int TO_WIDTH   = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  arm_i,
    input  logic                  abort_i,
    input  logic                  edge_i,
    input  logic [DATA_WIDTH-1:0] level_i,
    input  logic [CNT_WIDTH-1:0]  holdoff_i,
    input  logic [CNT_WIDTH-1:0]  cap_len_i,
    input  logic                  smp_valid_i,
    input  logic [DATA_WIDTH-1:0] smp_data_i,
    input  logic                  w_full_i,
    output logic                  w_en_o,
    output logic [DATA_WIDTH-1:0] w_data_o,
    output logic [2:0]            state_o,
    output logic                  done_o,
    output logic                  ovf_o,
    output logic                  trig_o
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_HOLDOFF = 3'd1;
    localparam logic [2:0] S_ARMED   = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

    logic [2:0]            state_q, state_d;
    logic                  edge_q, edge_d;
    logic [DATA_WIDTH-1:0] level_q, level_d;
    logic [CNT_WIDTH-1:0]  holdoff_q, holdoff_d;
    logic [CNT_WIDTH-1:0]  cap_len_q, cap_len_d;
    logic [CNT_WIDTH-1:0]  hcnt_q, hcnt_d;
    logic [CNT_WIDTH-1:0]  ccnt_q, ccnt_d;
    logic [DATA_WIDTH-1:0] prev_q, prev_d;
    logic                  prev_valid_q, prev_valid_d;
    logic                  ovf_q, ovf_d;
    logic                  w_en_q, w_en_d;
    logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
    logic                  trig_q, trig_d;

    logic [CNT_WIDTH-1:0]  hcnt_inc, ccnt_inc;
    logic                  level_hit, force_trig, trig_fire, write_req, arm_ok;

`ifdef CAPTURE_AUTO_TRIG_EN
    localparam logic [TO_WIDTH-1:0] TO_ONE = 1;
    logic [TO_WIDTH-1:0] to_cnt_q, to_cnt_d;

    // Held at zero outside ARMED so every entry starts a fresh timeout; saturates at all-ones.
    always_comb begin
        to_cnt_d = '0;
        if (state_q == S_ARMED)
            to_cnt_d = (to_cnt_q == '1) ? to_cnt_q : to_cnt_q + TO_ONE;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) to_cnt_q <= '0;
        else       to_cnt_q <= to_cnt_d;
    end

    assign force_trig = (to_cnt_q == '1);
`else
    logic unused_to_width;
    assign unused_to_width = ^{TO_WIDTH{1'b0}};
    assign force_trig      = 1'b0;
`endif

    assign hcnt_inc  = hcnt_q + CNT_ONE;
    assign ccnt_inc  = ccnt_q + CNT_ONE;
    assign level_hit = edge_q ? ((prev_q > level_q) && (smp_data_i <= level_q))
                              : ((prev_q < level_q) && (smp_data_i >= level_q));
    assign trig_fire = (state_q == S_ARMED) && smp_valid_i && ((prev_valid_q && level_hit) || force_trig);
    assign write_req = !abort_i && ((trig_fire && (cap_len_q != '0)) ||
                                    ((state_q == S_CAPTURE) && smp_valid_i));
    assign arm_ok    = !abort_i && arm_i && ((state_q == S_IDLE) || (state_q == S_DONE));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            edge_q       <= 1'b0;
            level_q      <= '0;
            holdoff_q    <= '0;
            cap_len_q    <= '0;
            hcnt_q       <= '0;
            ccnt_q       <= '0;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            ovf_q        <= 1'b0;
            w_en_q       <= 1'b0;
            w_data_q     <= '0;
            trig_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            edge_q       <= edge_d;
            level_q      <= level_d;
            holdoff_q    <= holdoff_d;
            cap_len_q    <= cap_len_d;
            hcnt_q       <= hcnt_d;
            ccnt_q       <= ccnt_d;
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
            ovf_q        <= ovf_d;
            w_en_q       <= w_en_d;
            w_data_q     <= w_data_d;
            trig_q       <= trig_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (arm_i) state_d = S_HOLDOFF;
            S_HOLDOFF: begin
                if (holdoff_q == '0)                         state_d = S_ARMED;
                else if (smp_valid_i && hcnt_inc == holdoff_q) state_d = S_ARMED;
            end
            S_ARMED:   if (trig_fire) state_d = (cap_len_q <= CNT_ONE) ? S_DONE : S_CAPTURE;
            S_CAPTURE: if (smp_valid_i && ccnt_inc == cap_len_q) state_d = S_DONE;
            default:   state_d = S_IDLE;
        endcase
        if (abort_i) state_d = S_IDLE;
    end

    always_comb begin
        edge_d       = edge_q;
        level_d      = level_q;
        holdoff_d    = holdoff_q;
        cap_len_d    = cap_len_q;
        hcnt_d       = hcnt_q;
        ccnt_d       = ccnt_q;
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        ovf_d        = ovf_q;
        w_en_d       = 1'b0;
        w_data_d     = w_data_q;
        trig_d       = trig_fire && !abort_i;
        if (arm_ok) begin
            edge_d       = edge_i;
            level_d      = level_i;
            holdoff_d    = holdoff_i;
            cap_len_d    = cap_len_i;
            hcnt_d       = '0;
            ccnt_d       = '0;
            prev_valid_d = 1'b0;
            ovf_d        = 1'b0;
        end
        if (!abort_i && smp_valid_i) begin
            if (state_q == S_HOLDOFF && holdoff_q != '0) hcnt_d = hcnt_inc;
            if (state_q == S_ARMED) begin
                prev_d       = smp_data_i;
                prev_valid_d = 1'b1;
                if (trig_fire) ccnt_d = CNT_ONE;
            end
            if (state_q == S_CAPTURE) ccnt_d = ccnt_inc;
        end
        // A full FIFO drops the sample but the frame counter has already advanced above.
        if (write_req) begin
            if (w_full_i) begin
                ovf_d = 1'b1;
            end else begin
                w_en_d   = 1'b1;
                w_data_d = smp_data_i;
            end
        end
    end

    assign w_en_o   = w_en_q;
    assign w_data_o = w_data_q;
    assign state_o  = state_q;
    assign done_o   = (state_q == S_DONE);
    assign ovf_o    = ovf_q;
    assign trig_o   = trig_q;
endmodule

// File: tb/tb_capture_ctrl.sv
// Directed bench for capture_ctrl; build with CAPTURE_AUTO_TRIG_EN to check the forced trigger.
module tb_capture_ctrl;
    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       arm_i, abort_i, edge_i, smp_valid_i, w_full_i;
    logic [7:0] level_i, holdoff_i, cap_len_i, smp_data_i;
    logic       w_en_o, done_o, ovf_o, trig_o;
    logic [7:0] w_data_o;
    logic [2:0] state_o;

    int n_checks = 0;
    int n_fail   = 0;

    capture_ctrl #(.DATA_WIDTH(8), .CNT_WIDTH(8), .TO_WIDTH(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .arm_i(arm_i), .abort_i(abort_i),
        .edge_i(edge_i), .level_i(level_i), .holdoff_i(holdoff_i), .cap_len_i(cap_len_i),
        .smp_valid_i(smp_valid_i), .smp_data_i(smp_data_i), .w_full_i(w_full_i),
        .w_en_o(w_en_o), .w_data_o(w_data_o), .state_o(state_o), .done_o(done_o),
        .ovf_o(ovf_o), .trig_o(trig_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        #1;
        if (w_en_o) $display("write data=%02h trig=%0b done=%0b", w_data_o, trig_o, done_o);
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic smp(input logic v, input logic [7:0] d);
        smp_valid_i = v;
        smp_data_i  = d;
        tick();
        smp_valid_i = 1'b0;
    endtask

    task automatic arm(input logic e, input logic [7:0] lvl, input logic [7:0] ho, input logic [7:0] len);
        edge_i = e; level_i = lvl; holdoff_i = ho; cap_len_i = len;
        arm_i = 1'b1;
        tick();
        arm_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; arm_i = 0; abort_i = 0; edge_i = 0; smp_valid_i = 0; w_full_i = 0;
        level_i = 0; holdoff_i = 0; cap_len_i = 0; smp_data_i = 0;
        tick(); tick();
        n_checks++; if (state_o !== 3'd0) begin n_fail++; $display("FAIL reset_state got %0d exp 0", state_o); end
        n_checks++; if (w_en_o !== 1'b0) begin n_fail++; $display("FAIL reset_w_en got %b exp 0", w_en_o); end
        n_checks++; if (w_data_o !== 8'h00) begin n_fail++; $display("FAIL reset_w_data got %h exp 00", w_data_o); end
        n_checks++; if ({done_o, ovf_o, trig_o} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b exp 000", {done_o, ovf_o, trig_o}); end
        rst_i = 1'b0;
        tick();
        n_checks++; if (state_o !== 3'd0) begin n_fail++; $display("FAIL idle_after_reset got %0d exp 0", state_o); end
    endtask

    task automatic test_rising();
        logic [7:0] s [8] = '{8'h10, 8'h20, 8'h70, 8'h90, 8'hA0, 8'hB0, 8'hC0, 8'hD0};
        int writes = 0;
        arm(1'b0, 8'h80, 8'd2, 8'd4);
        n_checks++; if (state_o !== 3'd1) begin n_fail++; $display("FAIL rise_holdoff_state got %0d exp 1", state_o); end
        for (int i = 0; i < 8; i++) begin
            smp(1'b1, s[i]);
            if (w_en_o) writes++;
            n_checks++; if (w_en_o !== (i >= 3 && i <= 6)) begin n_fail++; $display("FAIL rise_w_en[%0d] got %b exp %b", i, w_en_o, (i >= 3 && i <= 6)); end
            if (i >= 3 && i <= 6) begin
                n_checks++; if (w_data_o !== s[i]) begin n_fail++; $display("FAIL rise_w_data[%0d] got %h exp %h", i, w_data_o, s[i]); end
            end
            n_checks++; if (trig_o !== (i == 3)) begin n_fail++; $display("FAIL rise_trig[%0d] got %b exp %b", i, trig_o, (i == 3)); end
            n_checks++; if (done_o !== (i >= 6)) begin n_fail++; $display("FAIL rise_done[%0d] got %b exp %b", i, done_o, (i >= 6)); end
            if (i == 1) begin
                n_checks++; if (state_o !== 3'd2) begin n_fail++; $display("FAIL rise_armed_state got %0d exp 2", state_o); end
            end
        end
        n_checks++; if (writes !== 4) begin n_fail++; $display("FAIL rise_write_count got %0d exp 4", writes); end
    endtask

    task automatic test_falling();
        arm(1'b1, 8'h40, 8'd0, 8'd1);
        smp(1'b0, 8'h00);
        n_checks++; if (state_o !== 3'd2) begin n_fail++; $display("FAIL fall_armed got %0d exp 2", state_o); end
        smp(1'b1, 8'h50);
        smp(1'b1, 8'h40);
        n_checks++; if ({w_en_o, trig_o, done_o} !== 3'b111) begin n_fail++; $display("FAIL fall_hit got en/trig/done=%b exp 111", {w_en_o, trig_o, done_o}); end
        n_checks++; if (w_data_o !== 8'h40) begin n_fail++; $display("FAIL fall_data got %h exp 40", w_data_o); end
        smp(1'b1, 8'h30);
        n_checks++; if (w_en_o !== 1'b0) begin n_fail++; $display("FAIL fall_single_write got %b exp 0", w_en_o); end
        arm(1'b1, 8'h40, 8'd0, 8'd1);
        smp(1'b0, 8'h00);
        smp(1'b1, 8'h40);
        smp(1'b1, 8'h30);
        n_checks++; if ({w_en_o, trig_o} !== 2'b00) begin n_fail++; $display("FAIL fall_no_trig got en/trig=%b exp 00", {w_en_o, trig_o}); end
        n_checks++; if (state_o !== 3'd2) begin n_fail++; $display("FAIL fall_still_armed got %0d exp 2", state_o); end
    endtask

    task automatic test_full();
        abort_i = 1'b1; tick(); abort_i = 1'b0;
        arm(1'b0, 8'h80, 8'd0, 8'd3);
        smp(1'b0, 8'h00);
        smp(1'b1, 8'h10);
        smp(1'b1, 8'h90);
        n_checks++; if (w_en_o !== 1'b1 || w_data_o !== 8'h90) begin n_fail++; $display("FAIL full_first got en=%b data=%h exp 1/90", w_en_o, w_data_o); end
        w_full_i = 1'b1;
        smp(1'b1, 8'h91);
        w_full_i = 1'b0;
        n_checks++; if ({w_en_o, ovf_o} !== 2'b01) begin n_fail++; $display("FAIL full_drop got en/ovf=%b exp 01", {w_en_o, ovf_o}); end
        n_checks++; if (state_o !== 3'd3) begin n_fail++; $display("FAIL full_still_capture got %0d exp 3", state_o); end
        smp(1'b1, 8'h92);
        n_checks++; if (w_en_o !== 1'b1 || w_data_o !== 8'h92) begin n_fail++; $display("FAIL full_last got en=%b data=%h exp 1/92", w_en_o, w_data_o); end
        n_checks++; if ({done_o, ovf_o} !== 2'b11) begin n_fail++; $display("FAIL full_done_ovf got %b exp 11", {done_o, ovf_o}); end
        arm(1'b0, 8'h80, 8'd0, 8'd3);
        n_checks++; if (ovf_o !== 1'b0 || state_o !== 3'd1) begin n_fail++; $display("FAIL full_rearm got ovf=%b state=%0d exp 0/1", ovf_o, state_o); end
    endtask

    task automatic test_abort();
        abort_i = 1'b1; tick(); abort_i = 1'b0;
        arm(1'b0, 8'h80, 8'd0, 8'd4);
        smp(1'b0, 8'h00);
        smp(1'b1, 8'h10);
        smp(1'b1, 8'h90);
        n_checks++; if (w_en_o !== 1'b1) begin n_fail++; $display("FAIL abort_first_write got %b exp 1", w_en_o); end
        abort_i = 1'b1; arm_i = 1'b1;
        smp(1'b1, 8'hA0);
        abort_i = 1'b0; arm_i = 1'b0;
        n_checks++; if (state_o !== 3'd0 || w_en_o !== 1'b0) begin n_fail++; $display("FAIL abort_idle got state=%0d en=%b exp 0/0", state_o, w_en_o); end
        for (int i = 0; i < 3; i++) begin
            smp(1'b1, 8'hB0 + 8'(i));
            n_checks++; if (w_en_o !== 1'b0 || state_o !== 3'd0) begin n_fail++; $display("FAIL abort_quiet[%0d] got en=%b state=%0d exp 0/0", i, w_en_o, state_o); end
        end
        n_checks++; if (ovf_o !== 1'b0) begin n_fail++; $display("FAIL abort_ovf got %b exp 0", ovf_o); end
    endtask

    task automatic test_len0();
        arm(1'b0, 8'h80, 8'd0, 8'd0);
        smp(1'b0, 8'h00);
        smp(1'b1, 8'h10);
        smp(1'b1, 8'h90);
        n_checks++; if ({trig_o, w_en_o, done_o} !== 3'b101) begin n_fail++; $display("FAIL len0 got trig/en/done=%b exp 101", {trig_o, w_en_o, done_o}); end
        n_checks++; if (state_o !== 3'd4) begin n_fail++; $display("FAIL len0_state got %0d exp 4", state_o); end
    endtask

    task automatic test_auto_trig();
        logic auto_en;
        logic [2:0] exp_state;
`ifdef CAPTURE_AUTO_TRIG_EN
        auto_en = 1'b1;
`else
        auto_en = 1'b0;
`endif
        exp_state = auto_en ? 3'd4 : 3'd2;
        arm(1'b0, 8'h80, 8'd0, 8'd2);
        smp(1'b0, 8'h00);
        n_checks++; if (state_o !== 3'd2) begin n_fail++; $display("FAIL auto_armed got %0d exp 2", state_o); end
        for (int i = 0; i < 20; i++) begin
            smp(1'b1, 8'h00);
            n_checks++; if (trig_o !== (auto_en && i == 15)) begin n_fail++; $display("FAIL auto_trig[%0d] got %b exp %b", i, trig_o, (auto_en && i == 15)); end
        end
        n_checks++; if (state_o !== exp_state) begin n_fail++; $display("FAIL auto_final_state got %0d exp %0d", state_o, exp_state); end
    endtask

    initial begin
        test_reset();
        test_rising();
        test_falling();
        test_full();
        test_abort();
        test_len0();
        test_auto_trig();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/capture_ctrl.md
# capture_ctrl

Single-clock capture sequencer on the write side of the sample FIFO. It takes the ADC sample stream and applies a holdoff period. It then searches for a level-crossing trigger and writes exactly the requested number of samples into the FIFO write port, starting with the trigger sample. It then parks in DONE until re-armed, so the read side drains one clean, trigger-aligned frame.

## Interface
- DATA_WIDTH, 8, sample and trigger-level width (unsigned).
- CNT_WIDTH, 8, width of holdoff and capture-length counters.
- TO_WIDTH, 16, width of auto-trigger timeout counter (used only with the macro).
- clk_i  input  1  ADC/write-domain clock.
- rst_i  input  1  reset, asynchronous, active-high.
- arm_i  input  1  start/restart a capture; sampled in IDLE and DONE.
- abort_i  input  1  return to IDLE; overrides everything except reset.
- edge_i  input  1  trigger slope: 0 rising, 1 falling.
- level_i  input  DATA_WIDTH  trigger level.
- holdoff_i  input  CNT_WIDTH  valid samples ignored before arming.
- cap_len_i  input  CNT_WIDTH  samples written per capture.
- smp_valid_i  input  1  sample strobe.
- smp_data_i  input  DATA_WIDTH  sample value.
- w_full_i  input  1  FIFO full, already in this clock domain.
- w_en_o  output  1  FIFO write enable, registered.
- w_data_o  output  DATA_WIDTH  FIFO write data, registered.
- state_o  output  3  current state encoding.
- done_o  output  1  high while in DONE.
- ovf_o  output  1  sticky: at least one capture sample was dropped on full.
- trig_o  output  1  one-cycle pulse on trigger detection.

## Operation
- States and encodings: IDLE=0, HOLDOFF=1, ARMED=2, CAPTURE=3, DONE=4.
- IDLE or DONE with arm_i=1:
  - latch edge_i, level_i, holdoff_i and cap_len_i.
  - clear ovf_o, holdoff counter, capture counter and prev_valid.
  - go to HOLDOFF.
  - Config inputs are ignored at all other times.
- HOLDOFF: count smp_valid_i cycles. Go to ARMED once the count equals the latched holdoff, so exactly that many samples are skipped. A holdoff of 0 goes to ARMED on the next clock, and no samples are skipped.
- ARMED:
  - Each valid sample updates prev, and the first one sets prev_valid.
  - Trigger requires prev_valid and a valid sample, and is tested against the previous sample.
  - Rising trigger: prev < level and cur >= level.
  - Falling trigger: prev > level and cur <= level.
  - Comparisons are unsigned and full DATA_WIDTH.
  - On trigger: trig_o pulses and the trigger sample counts as capture sample 1.
  - If cap_len = 0, go to DONE with no write. Otherwise go to CAPTURE, and go straight to DONE if cap_len = 1.
- CAPTURE:
  - Each valid sample increments the capture counter and requests a write.
  - When the counter reaches cap_len, go to DONE on the same edge as the last write request.
- Write request with w_full_i=1 at request time: the sample is dropped, ovf_o is set, and the counter still advances so frame timing is preserved.
- Samples in IDLE, HOLDOFF, ARMED (other than the trigger sample) and DONE are never written.
- abort_i=1 in any state: go to IDLE on the next edge, suppress any write request that cycle, leave ovf_o unchanged.
- abort_i and arm_i both high: abort wins.
- Counters are exactly CNT_WIDTH bits and cannot wrap, because comparison against the latched value stops them.

## Timing
- Reset values:
  - state IDLE.
  - w_en_o=0, w_data_o=0, done_o=0, ovf_o=0, trig_o=0.
  - All counters and prev registers 0, prev_valid=0.
- Write latency: smp_valid_i in cycle N gives w_en_o=1 and w_data_o=sample in cycle N+1. w_en_o is a single-cycle pulse per sample.
- trig_o is high in cycle N+1 for a trigger sample in cycle N, aligned with that sample's w_en_o.
- done_o rises in the cycle after the last write request, coincident with the last w_en_o.
- Back-to-back valid samples every cycle are supported with no bubbles.
- Reset mid-capture: outputs return to reset values asynchronously, and a partial frame may remain in the FIFO. Flushing it is the FIFO owner's job.

## Configuration
- CAPTURE_AUTO_TRIG_EN defined:
  - ARMED runs a TO_WIDTH-bit clock-cycle counter, cleared on entry to ARMED.
  - When the counter reaches all-ones with no trigger, force a trigger on the next valid sample, with no level test.
  - trig_o pulses as normal, so free-run display works on flat signals.
- Undefined: no counter exists, and ARMED waits indefinitely.

## Test plan
- Rising trigger:
  - Stimulus: arm with holdoff=2, level=0x80, len=4, edge=0; feed 0x10,0x20,0x70,0x90,0xA0,0xB0,0xC0,0xD0.
  - Response: first two samples skipped; writes of 0x90,0xA0,0xB0,0xC0 in the cycle after each sample; trig_o aligned with the 0x90 write; done_o high after 0xC0; 0xD0 not written.
- Falling trigger, level=0x40, len=1:
  - Stimulus: samples 0x50,0x40.
  - Response: single write 0x40, then DONE.
  - Stimulus: samples 0x40,0x30.
  - Response: no trigger.
- Full during capture:
  - Stimulus: hold w_full_i=1 for sample 2 of len=3.
  - Response: two writes, ovf_o=1, DONE after sample 3. Re-arm clears ovf_o.
- Abort:
  - Stimulus: abort_i in CAPTURE after one write, with arm_i also high.
  - Response: IDLE next cycle, no further w_en_o.
- cap_len=0:
  - Stimulus: trigger occurs.
  - Response: trig_o pulses, zero writes, done_o high.
- With CAPTURE_AUTO_TRIG_EN and TO_WIDTH=4:
  - Stimulus: constant 0x00 input.
  - Response: forced trigger on first valid sample after 15 ARMED cycles.
  - Stimulus: same test without the macro.
  - Response: stays ARMED.
